// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V MEM stage with byte-serial load/store port
module mem_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  // EX_MEM side
  input  logic                  rdE_in,
  input  logic [4:0]            rdIdx_in,
  input  logic [31:0]           rdData_in,
  input  logic                  memE_in,
  input  logic                  memWe_in,
  input  logic [1:0]            memWidth_in,
  input  logic                  memSigned_in,
  input  logic [31:0]           storeData_in,
  // MEM_WB side
  output logic                  rdE_out,
  output logic [4:0]            rdIdx_out,
  output logic [31:0]           rdData_out,
  output logic                  stall_out,
  // memory controller byte port
  output logic                  mem_req_out,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [7:0]            mem_wdata_out,
  input  logic [7:0]            mem_rdata_in,
  input  logic                  mem_ack_in
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [1:0]            width_q, width_d;
  logic                  signed_q, signed_d;
  logic [31:0]           sdata_q, sdata_d;
  logic                  rde_q, rde_d;
  logic [4:0]            rdidx_q, rdidx_d;
  logic [31:0]           rbuf_q, rbuf_d;

  logic [1:0]            last_cnt;
  logic [4:0]            byte_lsb;
  logic [31:0]           load_result;
  logic                  stall_raw;

  // Index of the final byte of the latched access: 1, 2 or 4 bytes.
  always_comb begin
    case (width_q)
      2'b00:   last_cnt = 2'd0;
      2'b01:   last_cnt = 2'd1;
      default: last_cnt = 2'd3;
    endcase
  end

  assign byte_lsb = {cnt_q, 3'b000};

  // Sign- or zero-extend the reassembled little-endian load buffer.
  always_comb begin
    case (width_q)
      2'b00:   load_result = {{24{signed_q & rbuf_q[7]}}, rbuf_q[7:0]};
      2'b01:   load_result = {{16{signed_q & rbuf_q[15]}}, rbuf_q[15:0]};
      default: load_result = rbuf_q;
    endcase
  end

  // Next-state and output decode for the IDLE/ACCESS/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    width_d       = width_q;
    signed_d      = signed_q;
    sdata_d       = sdata_q;
    rde_d         = rde_q;
    rdidx_d       = rdidx_q;
    rbuf_d        = rbuf_q;
    rdE_out       = 1'b0;
    rdIdx_out     = 5'd0;
    rdData_out    = 32'd0;
    stall_raw     = 1'b0;
    mem_req_out   = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (memE_in) begin
          // Bubble MEM_WB while the memory op is captured.
          stall_raw = 1'b1;
          addr_d    = ADDR_WIDTH'(rdData_in);
          we_d      = memWe_in;
          width_d   = memWidth_in;
          signed_d  = memSigned_in;
          sdata_d   = storeData_in;
          rde_d     = rdE_in;
          rdidx_d   = rdIdx_in;
          cnt_d     = 2'd0;
          rbuf_d    = 32'd0;
          state_d   = S_ACCESS;
        end else begin
          rdE_out    = rdE_in;
          rdIdx_out  = rdIdx_in;
          rdData_out = rdData_in;
        end
      end

      S_ACCESS: begin
        stall_raw     = 1'b1;
        mem_req_out   = 1'b1;
        mem_we_out    = we_q;
        mem_addr_out  = addr_q + ADDR_WIDTH'(cnt_q);
        mem_wdata_out = sdata_q[byte_lsb +: 8];
        if (mem_ack_in) begin
          if (!we_q) begin
            rbuf_d[byte_lsb +: 8] = mem_rdata_in;
          end
          if (cnt_q == last_cnt) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      S_DONE: begin
        // The EX_MEM op is still visible here; always return to IDLE so it
        // cannot start a second transaction.
        if (!we_q) begin
          rdE_out    = rde_q;
          rdIdx_out  = rdidx_q;
          rdData_out = load_result;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset overrides the stall at once, even while an access was in flight.
  assign stall_out = stall_raw & rst_in;

  // State and latched-operand registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      width_q  <= 2'd0;
      signed_q <= 1'b0;
      sdata_q  <= 32'd0;
      rde_q    <= 1'b0;
      rdidx_q  <= 5'd0;
      rbuf_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      width_q  <= width_d;
      signed_q <= signed_d;
      sdata_q  <= sdata_d;
      rde_q    <= rde_d;
      rdidx_q  <= rdidx_d;
      rbuf_q   <= rbuf_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdE_in;
  logic [4:0]  rdIdx_in;
  logic [31:0] rdData_in;
  logic        memE_in;
  logic        memWe_in;
  logic [1:0]  memWidth_in;
  logic        memSigned_in;
  logic [31:0] storeData_in;
  logic        rdE_out;
  logic [4:0]  rdIdx_out;
  logic [31:0] rdData_out;
  logic        stall_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [7:0]  mem_wdata_out;
  logic [7:0]  mem_rdata_in;
  logic        mem_ack_in;

  always #5 clk_in = ~clk_in;

  mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdE_in        (rdE_in),
    .rdIdx_in      (rdIdx_in),
    .rdData_in     (rdData_in),
    .memE_in       (memE_in),
    .memWe_in      (memWe_in),
    .memWidth_in   (memWidth_in),
    .memSigned_in  (memSigned_in),
    .storeData_in  (storeData_in),
    .rdE_out       (rdE_out),
    .rdIdx_out     (rdIdx_out),
    .rdData_out    (rdData_out),
    .stall_out     (stall_out),
    .mem_req_out   (mem_req_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_rdata_in  (mem_rdata_in),
    .mem_ack_in    (mem_ack_in)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Byte-addressed memory seen by the controller side.
  logic [7:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rdE_in = 0; rdIdx_in = 0; rdData_in = 0; memE_in = 0; memWe_in = 0;
    memWidth_in = 0; memSigned_in = 0; storeData_in = 0;
    mem_rdata_in = 0; mem_ack_in = 0;
  endtask

  task automatic put(input logic [31:0] a, input logic [7:0] v);
    mem[a] = v;
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  // Expected load value from the memory model: little-endian, then extended.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input bit sg);
    logic [31:0] v;
    logic [31:0] k;
    v = 0;
    for (int i = 0; i < nbytes(w); i++) begin
      k = a + i;
      v = v | (32'(mem[k]) << (8 * i));
    end
    if (w == 2'b00 && sg && v[7])  v = v | 32'hFFFF_FF00;
    if (w == 2'b01 && sg && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic alu_op(input bit rde, input logic [4:0] idx, input logic [31:0] d);
    memE_in = 0; memWe_in = 1'($urandom); memWidth_in = 2'($urandom);
    memSigned_in = 1'($urandom); storeData_in = $urandom;
    rdE_in = rde; rdIdx_in = idx; rdData_in = d;
    mem_ack_in = 1'($urandom); mem_rdata_in = 8'($urandom);
    #1;
    chk("alu_rde", rdE_out, rde);
    chk("alu_idx", rdIdx_out, idx);
    chk("alu_data", rdData_out, d);
    chk("alu_stall", stall_out, 0);
    chk("alu_req", mem_req_out, 0);
    @(posedge clk_in); #1;
  endtask

  // One load/store as seen from pipeline and controller. abort_after >= 0
  // pulls reset after that many acknowledged bytes.
  task automatic do_op(input bit we, input logic [1:0] w, input bit sg,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] idx, input bit rde,
                       input int minwait, input int maxwait, input int abort_after);
    int nb;
    int waits;
    int stalls;
    int exp_stalls;
    logic [31:0] k;
    logic [31:0] expd;
    nb = nbytes(w);
    for (int i = 0; i < nb; i++) begin
      k = a + i;
      if (!mem.exists(k)) mem[k] = 8'($urandom);
    end
    expd = ref_load(a, w, sg);
    stalls = 0;

    memE_in = 1; memWe_in = we; memWidth_in = w; memSigned_in = sg;
    rdData_in = a; storeData_in = sd; rdIdx_in = idx; rdE_in = rde;
    mem_ack_in = 1'($urandom); mem_rdata_in = 8'($urandom);
    #1;
    chk("start_stall", stall_out, 1);
    chk("start_req", mem_req_out, 0);
    chk("start_bub_rde", rdE_out, 0);
    chk("start_bub_idx", rdIdx_out, 0);
    chk("start_bub_data", rdData_out, 0);
    stalls += int'(stall_out);
    @(posedge clk_in); #1;
    exp_stalls = 1 + nb;

    for (int b = 0; b < nb; b++) begin
      k = a + b;
      if (b == abort_after) begin
        mem_ack_in = 0;
        #1;
        rst_in = 0;
        #1;
        chk("rst_req", mem_req_out, 0);
        chk("rst_stall", stall_out, 0);
        @(posedge clk_in); #1;
        rst_in = 1;
        return;
      end
      waits = $urandom_range(maxwait, minwait);
      exp_stalls += waits;
      for (int j = 0; j <= waits; j++) begin
        mem_ack_in = (j == waits);
        mem_rdata_in = mem_ack_in ? mem[k] : 8'($urandom);
        #1;
        chk("acc_req", mem_req_out, 1);
        chk("acc_we", mem_we_out, we);
        chk("acc_addr", mem_addr_out, k);
        chk("acc_wdata", mem_wdata_out, sd[8*b +: 8]);
        chk("acc_stall", stall_out, 1);
        chk("acc_bub_rde", rdE_out, 0);
        chk("acc_bub_data", rdData_out, 0);
        stalls += int'(stall_out);
        if (mem_ack_in && we) mem[k] = sd[8*b +: 8];
        @(posedge clk_in); #1;
      end
    end

    mem_ack_in = 1'($urandom); mem_rdata_in = 8'($urandom);
    #1;
    chk("done_stall", stall_out, 0);
    chk("done_req", mem_req_out, 0);
    chk("stall_cycles", stalls, exp_stalls);
    chk("done_rde", rdE_out, we ? 1'b0 : rde);
    chk("done_idx", rdIdx_out, we ? 5'd0 : idx);
    chk("done_data", rdData_out, we ? 32'd0 : expd);
    @(posedge clk_in); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] a;
    rst_in = 0;
    idle_inputs();
    #2;
    chk("rst_rde", rdE_out, 0);
    chk("rst_idx", rdIdx_out, 0);
    chk("rst_data", rdData_out, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_req", mem_req_out, 0);
    chk("rst_we", mem_we_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_wdata", mem_wdata_out, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1;

    alu_op(1, 5'd5, 32'h1234);

    put(32'h100, 8'h78); put(32'h101, 8'h56); put(32'h102, 8'h34); put(32'h103, 8'h12);
    do_op(0, 2'b10, 0, 32'h100, $urandom, 5'd3, 1, 0, 0, -1);

    put(32'h20, 8'h80);
    do_op(0, 2'b00, 1, 32'h20, $urandom, 5'd4, 1, 0, 0, -1);
    do_op(0, 2'b00, 0, 32'h20, $urandom, 5'd4, 1, 0, 0, -1);
    put(32'h40, 8'hFE); put(32'h41, 8'hFF);
    do_op(0, 2'b01, 1, 32'h40, $urandom, 5'd6, 1, 0, 0, -1);

    do_op(1, 2'b01, 0, 32'hFFFF_FFFF, 32'hAABB_CCDD, 5'd9, 1, 2, 2, -1);

    put(32'h200, 8'h11); put(32'h201, 8'h22); put(32'h202, 8'h33); put(32'h203, 8'h44);
    do_op(0, 2'b10, 0, 32'h200, $urandom, 5'd2, 1, 0, 0, 2);
    put(32'h300, 8'h5A);
    do_op(0, 2'b00, 1, 32'h300, $urandom, 5'd8, 1, 0, 0, -1);

    do_op(0, 2'b10, 0, 32'h100, $urandom, 5'd1, 1, 0, 1, -1);
    alu_op(1, 5'd7, 32'hCAFE_0007);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        alu_op(1'($urandom), 5'($urandom), $urandom);
      end else begin
        w = $urandom_range(2, 0);
        case ($urandom_range(2, 0))
          0:       a = $urandom;
          1:       a = 32'hFFFF_FFFC + $urandom_range(3, 0);
          default: a = $urandom_range(63, 0);
        endcase
        do_op(1'($urandom), 2'(w == 2 ? $urandom_range(3, 2) : w), 1'($urandom), a,
              $urandom, 5'($urandom), 1'($urandom), 0, 3,
              ($urandom_range(19, 0) == 0) ? $urandom_range(3, 0) : -1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
